// File: rtl/seq_detect_param_if.sv
// Configuration, serial-bit and status bundle for the parametrised pattern detector.
// The bench drives the master side and the detector sits on the slave side.
interface seq_detect_param_if #(
   parameter int PAT_W = 8,
   parameter int CNT_W = 8,
   parameter int LEN_W = $clog2(PAT_W + 1)
);
   logic             cfg_load;
   logic [PAT_W-1:0] pattern;
   logic [LEN_W-1:0] pat_len;
   logic             overlap_en;
   logic             i_valid;
   logic             i;
   logic             count_clear;
   logic             o;
   logic [CNT_W-1:0] match_count;
   logic             busy;

   modport master (
      output cfg_load, pattern, pat_len, overlap_en, i_valid, i, count_clear,
      input  o, match_count, busy
   );

   modport slave (
      input  cfg_load, pattern, pat_len, overlap_en, i_valid, i, count_clear,
      output o, match_count, busy
   );
endinterface

// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime pattern of 1..PAT_W bits.
// Supports overlap and non-overlap modes and keeps a saturating match count.
module seq_detect_param #(
   parameter int PAT_W = 8,
   parameter int CNT_W = 8,
   parameter int LEN_W = $clog2(PAT_W + 1)
) (
   input logic               clk,
   input logic               rst,
   seq_detect_param_if.slave bus
);
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);
   localparam logic [LEN_W-1:0] DEF_LEN = LEN_W'((PAT_W < 4) ? PAT_W : 4);
   localparam logic [PAT_W-1:0] DEF_PAT = PAT_W'(13);

   logic [PAT_W-1:0] hist_r, pat_r, hist_nxt, mask;
   logic [LEN_W-1:0] len_r, fill_r, fill_inc, fill_nxt, len_ld;
   logic             ovl_r, o_r, busy_r, accept, hit;
   logic [CNT_W-1:0] cnt_r;

   always_comb begin
      accept   = bus.i_valid && !bus.cfg_load;
      hist_nxt = {hist_r[PAT_W-2:0], bus.i};
      fill_inc = (fill_r == MAX_LEN) ? fill_r : fill_r + LEN_W'(1);
      // Shifting by PAT_W yields zero, so a full-length pattern masks every bit.
      mask     = ~({PAT_W{1'b1}} << len_r);
      hit      = accept && (((hist_nxt ^ pat_r) & mask) == '0) && (fill_inc >= len_r);
      fill_nxt = (hit && !ovl_r) ? '0 : fill_inc;
      len_ld   = bus.pat_len;
      if (bus.pat_len == '0)
         len_ld = LEN_W'(1);
      else if (bus.pat_len > MAX_LEN)
         len_ld = MAX_LEN;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hist_r <= '0;
         fill_r <= '0;
         busy_r <= 1'b0;
         pat_r  <= DEF_PAT;
         len_r  <= DEF_LEN;
         ovl_r  <= 1'b1;
         o_r    <= 1'b0;
      end else if (bus.cfg_load) begin
         // The bit presented with a load belongs to neither pattern and is dropped.
         hist_r <= '0;
         fill_r <= '0;
         busy_r <= 1'b0;
         pat_r  <= bus.pattern;
         len_r  <= len_ld;
         ovl_r  <= bus.overlap_en;
         o_r    <= 1'b0;
      end else begin
         o_r <= hit;
         if (accept) begin
            hist_r <= hist_nxt;
            fill_r <= fill_nxt;
            busy_r <= (fill_nxt != '0);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_r <= '0;
      else if (bus.count_clear)
         cnt_r <= '0;
      else if (hit && (cnt_r != '1))
         cnt_r <= cnt_r + CNT_W'(1);
   end

   assign bus.o           = o_r;
   assign bus.match_count = cnt_r;
   assign bus.busy        = busy_r;
endmodule
